// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: one 128-bit state in, BYTES_PER_CYCLE bytes substituted per clock, result out after 16/BYTES_PER_CYCLE edges.
// Valid/ready on both sides; accepts only in IDLE, holds the result stable in DONE until out_ready.

module sub_bytes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), built by square-and-multiply
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end

endmodule

module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       r_state;
  state_t       w_next_state;
  logic [3:0]   r_idx;
  logic [127:0] r_work;
  logic [127:0] r_state_out;
  logic [127:0] w_work_nxt;
  logic         w_last;
  logic [7:0]   w_byte_in [BYTES_PER_CYCLE];
  logic [7:0]   w_sub     [BYTES_PER_CYCLE];

  // r_idx is always a multiple of BYTES_PER_CYCLE, so the chunk never crosses byte 15
  always_comb begin
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      w_byte_in[k] = r_work[127 - 8*(int'(r_idx) + k) -: 8];
    end
  end

  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
    sub_bytes_sbox u_sbox (
      .i_byte (w_byte_in[k]),
      .o_byte (w_sub[k])
    );
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
        if (({1'b0, r_idx} + 5'(k)) == 5'(j)) w_work_nxt[127 - 8*j -: 8] = w_sub[k];
      end
    end
    w_last = (({1'b0, r_idx} + 5'(BYTES_PER_CYCLE)) == 5'd16);
  end

  always_comb begin
    w_next_state = r_state;
    in_ready     = (r_state == IDLE);
    busy         = (r_state != IDLE);
    out_valid    = (r_state == DONE);
    state_out    = r_state_out;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_work      <= '0;
      r_state_out <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_work <= state_in;
            r_idx  <= 4'd0;
          end
        end
        RUN: begin
          r_work <= w_work_nxt;
          r_idx  <= r_idx + 4'(BYTES_PER_CYCLE);
          if (w_last) r_state_out <= w_work_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
- Iterative AES SubBytes stage built around the existing S_Box lookup.
- Accepts one 128-bit state word, substitutes all 16 bytes using BYTES_PER_CYCLE S_Box instances per clock, and presents the substituted state downstream.
- Sits between the AddRoundKey output and the ShiftRows input in the round datapath.
- Uses valid/ready handshakes on both sides so the round controller can stall it.

Parameters:
- BYTES_PER_CYCLE, 1, number of parallel S_Box instances. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error. The number of processing cycles is NCYC = 16/BYTES_PER_CYCLE.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous reset, active-low, sampled on the rising edge of clk.
- in_valid  input  1  upstream has a valid state on state_in.
- in_ready  output  1  block can accept; high only in IDLE.
- state_in  input  128  input state; byte i = state_in[127-8i -: 8] (byte 0 is the MSB byte).
- out_valid  output  1  state_out holds the completed SubBytes result.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  substituted state, same byte ordering as state_in.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE. 4-bit byte index idx, incremented by BYTES_PER_CYCLE in RUN.
- Reset (rst_n=0 at an edge): state=IDLE, idx=0, internal state register=0, state_out=0, out_valid=0. in_ready=1 and busy=0 after the edge.
- Reset wins over every other event. Reset mid-RUN or mid-DONE discards the block silently; no out_valid pulse follows.
- in_ready = (state==IDLE), combinational from state only. There is no same-cycle bypass from DONE to IDLE.
- IDLE:
  - On an edge with in_valid=1, capture state_in into the working register, set idx=0, go to RUN.
  - With in_valid=0, stay in IDLE.
- RUN:
  - Each edge replaces bytes idx .. idx+BYTES_PER_CYCLE-1 of the working register with S_Box(byte), then idx += BYTES_PER_CYCLE (mod 16).
  - On the edge that processes the final chunk (idx+BYTES_PER_CYCLE == 16): go to DONE, set out_valid=1, idx wraps to 0.
  - in_valid is ignored in RUN (in_ready=0).
- Latency: input accepted at edge T gives out_valid=1 after edge T+NCYC.
  - NCYC=16 for BYTES_PER_CYCLE=1.
  - NCYC=1 for BYTES_PER_CYCLE=16.
- DONE:
  - state_out = working register, held stable while out_valid=1 and out_ready=0, for any length of stall.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. in_ready rises after that edge.
  - state_out keeps its last value in IDLE.
- out_ready has no effect outside DONE.
- Minimum accept-to-accept spacing is NCYC+2 cycles.
- S_Box instances are purely combinational; all registering is in this block.

Test Plan:
- Reset, then state_in = 00010203..0e0f with in_valid=1 for one cycle and out_ready=1 (BYTES_PER_CYCLE=1) -> out_valid rises exactly 16 edges after acceptance with state_out = 637c777bf26b6fc53001672bfed7ab76; in_ready=0 throughout RUN/DONE, 1 again the cycle after the out handshake.
- All-0x00 input, then all-0x52 input, back to back -> outputs are all-0x63 and all-0x00 respectively; the second is accepted only after in_ready returns.
- Hold out_ready=0 for 10 cycles after out_valid -> state_out and out_valid remain constant; in_valid pulses during the stall are not accepted. Release out_ready -> single handshake, return to IDLE.
- Drop rst_n for one edge during RUN (idx=8) -> after that edge out_valid=0, state_out=0, in_ready=1; a new input then completes with the correct result and full latency.
- Repeat the first vector with BYTES_PER_CYCLE=4 and 16 -> identical state_out, with out_valid after 4 and 1 edge(s) respectively.
- Input ff fe fd .. f0 (byte 0 = ff) -> state_out = 16bb54b00f2d99416842e6bf0d89a18c.
